// File: rtl/sipo_dbuf.sv
// sipo_dbuf -- double-buffered serial-in / parallel-out collector for the
// PE array Y operand path.
//
// Samples are gathered into a fill register, lane 0 first. A completed frame
// (LANES samples, or fewer when closed early with s_in_last) moves to the
// output bank. The PE array drains the bank with p_out_v / p_out_rdy. If the
// bank is still occupied when a frame completes, the frame stays parked in
// the fill register and ff is set. Input is then stalled until the bank
// drains.
//
// Build option:
//   SIPO_DBUF_ROTATE_EN  defined   -> shift_v rotates the held frame
//                                     (top lane receives old lane 0)
//                        undefined -> shift_v zero-fills the top lane
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   ce         clock enable; all state holds when low
//   s_in_v     input sample valid
//   s_in_rdy   block can accept a sample
//   s_in       input sample (DW bits, packed complex)
//   s_in_last  accepted sample closes the frame early
//   shift_v    shift the held output frame down one lane
//   p_out_v    output bank holds a frame
//   p_out_rdy  consumer takes the frame
//   p_out      output bank; lane k = p_out[k*DW +: DW]
//   fill_cnt   lanes written in the current fill frame

module sipo_dbuf #(
    parameter int DW    = 32,
    parameter int LANES = 8,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                s_in_v,
    output logic                s_in_rdy,
    input  logic [DW-1:0]       s_in,
    input  logic                s_in_last,
    input  logic                shift_v,
    output logic                p_out_v,
    input  logic                p_out_rdy,
    output logic [LANES*DW-1:0] p_out,
    output logic [CW-1:0]       fill_cnt
);

    logic [LANES*DW-1:0] fill_reg;
    logic [LANES*DW-1:0] bank;
    logic [LANES*DW-1:0] new_frame;
    logic [LANES*DW-1:0] shifted;
    logic                ff;
    logic                acc;
    logic                drain;
    logic                complete;

    // Registered state only (plus rst): p_out_rdy reaches s_in_rdy via ff.
    assign s_in_rdy = !ff && !rst;
    assign acc      = s_in_v && s_in_rdy;
    assign drain    = p_out_v && p_out_rdy;
    assign complete = acc && (s_in_last || (fill_cnt == CW'(LANES - 1)));
    assign p_out    = bank;

    // Fill contents with the incoming sample dropped into lane fill_cnt.
    // Unwritten lanes are already zero because the fill register clears on
    // every completion.
    always_comb begin
        new_frame = fill_reg;
        for (int k = 0; k < LANES; k++) begin
            if (fill_cnt == CW'(k)) begin
                new_frame[k*DW +: DW] = s_in;
            end
        end
    end

`ifdef SIPO_DBUF_ROTATE_EN
    assign shifted = {bank[DW-1:0], bank[LANES*DW-1:DW]};
`else
    assign shifted = {{DW{1'b0}}, bank[LANES*DW-1:DW]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_reg <= '0;
            bank     <= '0;
            fill_cnt <= '0;
            ff       <= 1'b0;
            p_out_v  <= 1'b0;
        end else if (ce) begin
            if (drain) begin
                // Drain has priority over shift; the shift is dropped.
                if (ff) begin
                    // Parked frame replaces the drained one; no accept is
                    // possible this cycle because s_in_rdy is low.
                    bank     <= fill_reg;
                    fill_reg <= '0;
                    ff       <= 1'b0;
                end else if (complete) begin
                    bank     <= new_frame;
                    fill_reg <= '0;
                    fill_cnt <= '0;
                end else begin
                    p_out_v <= 1'b0;
                    if (acc) begin
                        fill_reg <= new_frame;
                        fill_cnt <= fill_cnt + CW'(1);
                    end
                end
            end else begin
                if (p_out_v && shift_v) begin
                    bank <= shifted;
                end
                if (complete) begin
                    fill_cnt <= '0;
                    if (!p_out_v) begin
                        bank     <= new_frame;
                        p_out_v  <= 1'b1;
                        fill_reg <= '0;
                    end else begin
                        fill_reg <= new_frame;
                        ff       <= 1'b1;
                    end
                end else if (acc) begin
                    fill_reg <= new_frame;
                    fill_cnt <= fill_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sipo_dbuf.sv
// Directed bench for sipo_dbuf (DW=32, LANES=8): a per-cycle vector table
// followed by hand-written multi-cycle sequences (shift, conflict, ce, reset).

module tb_sipo_dbuf;

    localparam int DW    = 32;
    localparam int LANES = 8;
    localparam int CW    = $clog2(LANES + 1);
    localparam int PW    = LANES * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          s_in_v;
    logic          s_in_rdy;
    logic [DW-1:0] s_in;
    logic          s_in_last;
    logic          shift_v;
    logic          p_out_v;
    logic          p_out_rdy;
    logic [PW-1:0] p_out;
    logic [CW-1:0] fill_cnt;

    int n_pass  = 0;
    int n_total = 0;

    sipo_dbuf #(.DW(DW), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .s_in_v    (s_in_v),
        .s_in_rdy  (s_in_rdy),
        .s_in      (s_in),
        .s_in_last (s_in_last),
        .shift_v   (shift_v),
        .p_out_v   (p_out_v),
        .p_out_rdy (p_out_rdy),
        .p_out     (p_out),
        .fill_cnt  (fill_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          ce;
        bit          v;
        logic [31:0] d;
        bit          last;
        bit          shift;
        bit          rdy;
        bit          e_pv;
        bit          e_rdy;
        int          e_cnt;
        bit          chk_p;
        int          p_first;
        int          p_n;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit c, bit v, int d, bit l, bit sh, bit rd,
                                bit e_pv, bit e_rdy, int e_cnt,
                                bit chk_p, int p_first, int p_n);
        vec_t x;
        x.rst = r; x.ce = c; x.v = v; x.d = d; x.last = l; x.shift = sh; x.rdy = rd;
        x.e_pv = e_pv; x.e_rdy = e_rdy; x.e_cnt = e_cnt;
        x.chk_p = chk_p; x.p_first = p_first; x.p_n = p_n;
        vecs.push_back(x);
    endfunction

    // Frame with lanes 0..n-1 = first, first+1, ... and zero above.
    function automatic logic [PW-1:0] frame(int first, int n);
        logic [PW-1:0] f;
        f = '0;
        for (int k = 0; k < n; k++) f[k*DW +: DW] = DW'(first + k);
        return f;
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input bit r, input bit c, input bit v, input int d,
                        input bit l, input bit sh, input bit rd);
        rst = r; ce = c; s_in_v = v; s_in = DW'(d); s_in_last = l;
        shift_v = sh; p_out_rdy = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input bit l, input bit rd);
        step(1'b0, 1'b1, 1'b1, d, l, 1'b0, rd);
    endtask

    logic [PW-1:0] exp_sh;

    initial begin
        rst = 1'b1; ce = 1'b1; s_in_v = 1'b1; s_in = '0; s_in_last = 1'b0;
        shift_v = 1'b0; p_out_rdy = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 5; i++) add(1, 1, 1, 32'hAA, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 1, 1, k, 0, 0, 0, k == 8, 1, k % 8, k == 8, 1, 8);
        for (int k = 9; k <= 16; k++)
            add(0, 1, 1, k, 0, 0, 0, 1, k != 16, k % 8, 1, 1, 8);
        add(0, 1, 1, 17, 0, 0, 1, 1, 1, 0, 1, 9, 8);        // parked frame swaps in
        for (int k = 17; k <= 23; k++)
            add(0, 1, 1, k, 0, 0, 0, 1, 1, k - 16, 1, 9, 8);
        add(0, 1, 1, 24, 0, 0, 1, 1, 1, 0, 1, 17, 8);       // complete + drain together
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 17, 8);        // drain, stale data holds
        add(0, 1, 1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 6, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        add(0, 1, 1, 7, 1, 0, 0, 1, 1, 0, 1, 5, 3);         // partial frame
        add(0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 5, 3);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ce, vecs[i].v, vecs[i].d, vecs[i].last,
                 vecs[i].shift, vecs[i].rdy);
            chk($sformatf("vec%0d p_out_v", i), PW'(p_out_v), PW'(vecs[i].e_pv));
            chk($sformatf("vec%0d s_in_rdy", i), PW'(s_in_rdy), PW'(vecs[i].e_rdy));
            chk($sformatf("vec%0d fill_cnt", i), PW'(fill_cnt), PW'(vecs[i].e_cnt));
            if (vecs[i].chk_p)
                chk($sformatf("vec%0d p_out", i), p_out, frame(vecs[i].p_first, vecs[i].p_n));
        end

        // ---------------- shift ----------------
        for (int k = 1; k <= 8; k++) send(k, 0, 0);
        chk("shift preload", p_out, frame(1, 8));
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 0);
        exp_sh = frame(4, 5);
`ifdef SIPO_DBUF_ROTATE_EN
        exp_sh = exp_sh | (frame(1, 3) << (5 * DW));
`endif
        chk("shift x3 p_out", p_out, exp_sh);
        chk("shift x3 p_out_v", PW'(p_out_v), PW'(1));
        step(0, 1, 0, 0, 0, 0, 1);
        chk("shift drain p_out_v", PW'(p_out_v), PW'(0));
        step(0, 1, 0, 0, 0, 1, 0);
        chk("shift idle ignored", p_out, exp_sh);

        // ---------------- drain beats shift ----------------
        for (int k = 1; k <= 8; k++) send(k, 0, 0);
        step(0, 1, 0, 0, 0, 1, 1);
        chk("conflict p_out", p_out, frame(1, 8));
        chk("conflict p_out_v", PW'(p_out_v), PW'(0));

        // ---------------- ce freeze ----------------
        for (int k = 1; k <= 8; k++) send(k, 0, 0);
        for (int k = 31; k <= 33; k++) send(k, 0, 0);
        chk("ce pre fill_cnt", PW'(fill_cnt), PW'(3));
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 99, 0, 1, 1);
            chk($sformatf("ce%0d fill_cnt", i), PW'(fill_cnt), PW'(3));
            chk($sformatf("ce%0d p_out", i), p_out, frame(1, 8));
            chk($sformatf("ce%0d p_out_v", i), PW'(p_out_v), PW'(1));
        end
        step(0, 1, 0, 0, 0, 0, 1);
        chk("ce drain p_out_v", PW'(p_out_v), PW'(0));
        for (int k = 34; k <= 38; k++) send(k, 0, 0);
        chk("ce frame p_out", p_out, frame(31, 8));
        chk("ce frame p_out_v", PW'(p_out_v), PW'(1));
        chk("ce frame fill_cnt", PW'(fill_cnt), PW'(0));

        // ---------------- reset mid-frame ----------------
        send(40, 0, 0);
        send(41, 0, 0);
        step(1, 1, 1, 42, 0, 0, 0);
        chk("rst p_out", p_out, '0);
        chk("rst p_out_v", PW'(p_out_v), PW'(0));
        chk("rst fill_cnt", PW'(fill_cnt), PW'(0));
        chk("rst s_in_rdy", PW'(s_in_rdy), PW'(0));
        step(0, 1, 0, 0, 0, 0, 0);
        chk("post rst s_in_rdy", PW'(s_in_rdy), PW'(1));
        send(1, 1, 0);
        chk("post rst frame", p_out, frame(1, 1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sipo_dbuf.md
# sipo_dbuf

Double-buffered, parametrised serial-in parallel-out collector for the PE array's Y operand path. It gathers LANES complex samples of DW bits into a fill register, then hands each completed frame to an output bank that the PE array drains with a valid/ready handshake. While the output bank holds a frame, the next frame keeps filling. It supports partial frames (`s_in_last`) and in-place lane shifting of the held frame (`shift_v`), so it replaces the fixed-size, handshake-less SIPO on the Y path.

## Interface
- `DW`, 32, sample width in bits (`DATA_WIDTH*2`, packed complex).
- `LANES`, 8, samples per frame (`PE_NUM`); ≥2.
- `CW`, `$clog2(LANES+1)`, width of `fill_cnt`.

Ports:
- `clk` input 1: the only clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `ce` input 1: clock enable; when low, all state holds.
- `s_in_v` input 1: input sample valid.
- `s_in_rdy` output 1: block can accept a sample.
- `s_in` input DW: input sample.
- `s_in_last` input 1: the accepted sample closes the frame early.
- `shift_v` input 1: shift the held output frame down one lane.
- `p_out_v` output 1: output bank holds a frame.
- `p_out_rdy` input 1: consumer takes the frame.
- `p_out` output LANES*DW: output bank; lane k is `p_out[k*DW +: DW]`.
- `fill_cnt` output CW: number of lanes written in the current fill frame.

## Operation
- **Accept.** A sample is accepted when `ce && s_in_v && s_in_rdy`.
  - It is written to fill lane `fill_cnt`; lane 0 is written first.
  - `fill_cnt` then increments.
- **Frame complete.** A frame completes on the accept of lane LANES-1, or on any accept with `s_in_last=1`.
  - Lanes not written are zero.
  - `fill_cnt` returns to 0 and the fill register clears.
- **Transfer.** A completed frame moves to the output bank when the bank is free.
  - The bank is free when `p_out_v=0`, or when the bank is being drained in the same cycle.
  - If the bank is not free, the frame is parked in the fill register and the full flag `ff` is set.
- **Backpressure.** `s_in_rdy = !ff && !rst`. While `ff` is set, no sample is accepted.
- **Drain.** The bank drains on `ce && p_out_v && p_out_rdy`.
  - If `ff` is set, the parked frame moves to the bank in the same cycle, `ff` clears, and `p_out_v` stays 1.
  - Otherwise `p_out_v` goes to 0 and `p_out` holds its stale value.
- **Shift.** On `ce && shift_v && p_out_v` with no drain that cycle:
  - lane k ← lane k+1 for k < LANES-1;
  - lane LANES-1 ← 0;
  - `p_out_v` is unchanged.
  - `shift_v` with `p_out_v=0` is ignored.
- **Simultaneous drain and shift:** the drain wins and the shift is dropped.
- **Simultaneous drain and frame completion with `ff=0`:** the new frame loads the bank directly and `p_out_v` stays 1.

## Timing
- Reset values, applied at the first rising edge with `rst=1`:
  - `p_out_v`=0, `p_out`=0, `fill_cnt`=0, `ff`=0, fill register =0;
  - `s_in_rdy`=0 while `rst` is high, and 1 in the first cycle after `rst` falls.
- Latency: completing accept at edge N → `p_out_v`=1 and frame on `p_out` after edge N, provided the bank is free.
- Back-to-back frames with the consumer always ready run at full rate, one sample per cycle, with no bubbles.
- `s_in_rdy` is combinational from registered state only. There is no combinational path from `p_out_rdy` to `s_in_rdy`; the path is registered through `ff`.
- `ce=0` freezes every register. Handshakes and shifts are not performed, and `s_in_rdy` keeps its value.
- Reset mid-frame discards both the fill contents and the bank contents.
- The `fill_cnt` wrap from LANES-1 to 0 occurs on the completing accept.

## Configuration
- `SIPO_DBUF_ROTATE_EN` defined: a shift rotates the frame; lane LANES-1 ← old lane 0.
- `SIPO_DBUF_ROTATE_EN` undefined: a shift zero-fills lane LANES-1, as specified above.
- All other behaviour is identical with or without the macro.

## Test plan
All scenarios use DW=32 and LANES=8.
- **Reset.** Assert `rst` for 5 cycles with `s_in_v=1`.
  - Expect `p_out_v`=0, `p_out`=0, `fill_cnt`=0 and `s_in_rdy`=0 throughout.
  - Expect `s_in_rdy`=1 one cycle after `rst` falls.
- **Full frame.** Stream samples 1..8 with `p_out_rdy=0`.
  - One cycle after sample 8, expect `p_out_v`=1 and lane k = k+1 (lane 0 = 1, lane 7 = 8).
  - Expect `fill_cnt`=0.
- **Backpressure.** Continue with samples 9..16 while `p_out_rdy=0`.
  - After 16, expect `s_in_rdy`=0; sample 17 is held.
  - Pulse `p_out_rdy` for 1 cycle. Next cycle expect `p_out` lanes = 9..16, `p_out_v`=1, `s_in_rdy`=1, then 17 accepted into lane 0.
- **Partial frame.** Send 5, 6, 7 with `s_in_last` on 7.
  - Expect lanes 0..2 = 5, 6, 7 and lanes 3..7 = 0.
- **Shift.** Hold frame 1..8 and assert `shift_v` for 3 cycles.
  - Expect lane 0 = 4, lanes 5..7 = 0.
  - With `SIPO_DBUF_ROTATE_EN` defined, expect lanes 5..7 = 1, 2, 3.
- **Conflict and `ce`.**
  - Assert `shift_v` and `p_out_rdy` in the same cycle: the frame drains unshifted.
  - Drop `ce` for 4 cycles mid-frame with `s_in_v=1`: `fill_cnt` and `p_out` hold, and no sample is lost or duplicated.
